// File: rtl/key_debouncer.sv
// Input-conditioning stage for the safe-cracking FSM: synchronises and debounces four
// active-low push-buttons and the programming switch, and derives press pulses and flags.
module key_debouncer #(
    parameter int CLOCK_HZ    = 50_000_000,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] KEY_n,
    input  logic       sw_raw,
    output logic [3:0] KEY_n_db,
    output logic       sw_db,
    output logic [3:0] key_press,
    output logic       key_valid,
    output logic [1:0] key_code,
    output logic       multi_press
);

    localparam int DB_CYCLES = CLOCK_HZ / 1000 * DEBOUNCE_MS;
    localparam int CNT_W     = $clog2(DB_CYCLES + 1);
    localparam int NCH       = 5;
    localparam int SW_CH     = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Channels 0..3 are the keys (inverted to active-high), channel 4 is the switch.
    logic [NCH-1:0]   raw_in;
    logic [NCH-1:0]   sync1_q, sync1_d;
    logic [NCH-1:0]   sync2_q, sync2_d;
    logic [NCH-1:0]   st_q, st_d;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];

    logic [3:0] key_press_q, key_press_d;
    logic       key_valid_q, key_valid_d;
    logic [1:0] key_code_q, key_code_d;
    logic       multi_press_q, multi_press_d;
    logic [2:0] pressed_cnt;

    assign raw_in = {sw_raw, ~KEY_n};

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first, so no path infers a latch.
        sync1_d = raw_in;
        sync2_d = sync1_q;
        st_d    = st_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != st_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    st_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Pulses and flags are taken from the next stable value so they align with the level change.
    always_comb begin
        key_press_d = st_d[3:0] & ~st_q[3:0];
        key_valid_d = |key_press_d;
        key_code_d  = '0;
        for (int i = 3; i >= 0; i--) begin
            if (key_press_d[i]) begin
                key_code_d = 2'(i);
            end
        end
        pressed_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            pressed_cnt = pressed_cnt + 3'(st_d[i]);
        end
        multi_press_d = (pressed_cnt >= 3'd2);
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            st_q          <= '0;
            key_press_q   <= '0;
            key_valid_q   <= 1'b0;
            key_code_q    <= '0;
            multi_press_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            st_q          <= st_d;
            key_press_q   <= key_press_d;
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
            multi_press_q <= multi_press_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign KEY_n_db    = ~st_q[3:0];
    assign sw_db       = st_q[SW_CH];
    assign key_press   = key_press_q;
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign multi_press = multi_press_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: directed scenarios plus random stimulus, all compared
// against a sliding-window reference model of the debounce rules.
module tb_key_debouncer;

    localparam int CLOCK_HZ    = 1000;
    localparam int DEBOUNCE_MS = 4;
    localparam int DB          = 4;
    localparam logic [12:0] RESET_VEC = {4'b1111, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] KEY_n = 4'b1111;
    logic       sw_raw = 1'b0;
    logic [3:0] KEY_n_db;
    logic       sw_db;
    logic [3:0] key_press;
    logic       key_valid;
    logic [1:0] key_code;
    logic       multi_press;

    int checks = 0;
    int errors = 0;

    key_debouncer #(
        .CLOCK_HZ   (CLOCK_HZ),
        .DEBOUNCE_MS(DEBOUNCE_MS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .KEY_n      (KEY_n),
        .sw_raw     (sw_raw),
        .KEY_n_db   (KEY_n_db),
        .sw_db      (sw_db),
        .key_press  (key_press),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .multi_press(multi_press)
    );

    always #5 clk = ~clk;

    // Reference model: a channel's level flips once the last DB synchronised samples
    // (raw values seen 2..DB+1 edges ago) all disagree with it.
    logic [DB:0][4:0] m_hist;
    logic [4:0]       m_st, m_next;
    logic [3:0]       m_press;
    logic             m_multi;
    logic [4:0]       raw_int;
    logic [12:0]      dut_vec, exp_vec;

    function automatic logic [4:0] settle(input logic [DB:0][4:0] hist, input logic [4:0] st);
        logic [4:0] nxt;
        int         disagree;
        nxt = st;
        for (int ch = 0; ch < 5; ch++) begin
            disagree = 0;
            for (int j = 1; j <= DB; j++) begin
                if (hist[j][ch] != st[ch]) disagree++;
            end
            if (disagree == DB) nxt[ch] = ~st[ch];
        end
        return nxt;
    endfunction

    function automatic logic [1:0] lowest(input logic [3:0] p);
        for (int i = 0; i < 4; i++) begin
            if (p[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    assign raw_int = {sw_raw, ~KEY_n};
    always_comb m_next = settle(m_hist, m_st);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hist  <= '0;
            m_st    <= '0;
            m_press <= '0;
            m_multi <= 1'b0;
        end else begin
            m_hist  <= {m_hist[DB-1:0], raw_int};
            m_st    <= m_next;
            m_press <= m_next[3:0] & ~m_st[3:0];
            m_multi <= ($countones(m_next[3:0]) >= 2);
        end
    end

    assign dut_vec = {KEY_n_db, sw_db, key_press, key_valid, key_code, multi_press};
    assign exp_vec = {~m_st[3:0], m_st[4], m_press, |m_press, lowest(m_press), m_multi};

    task automatic release_and_wait(input int n);
        @(negedge clk);
        KEY_n = 4'b1111;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", dut_vec, RESET_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== RESET_VEC) begin
                errors++;
                $display("FAIL idle_after_reset edge %0d: got %b want %b", e, dut_vec, RESET_VEC);
            end
        end
    endtask

    task automatic test_clean_press();
        int pulses = 0;
        @(negedge clk);
        KEY_n[2] = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL clean_press edge %0d: got %b want %b", e, dut_vec, exp_vec);
            end
            if (e == 5 || e == 6) begin
                checks++;
                if (KEY_n_db[2] !== (e < 6)) begin
                    errors++;
                    $display("FAIL clean_press_latency edge %0d: KEY_n_db=%b", e, KEY_n_db);
                end
            end
            if (key_valid) begin
                pulses++;
                checks++;
                if (e != 6 || key_press !== 4'b0100 || key_code !== 2'd2) begin
                    errors++;
                    $display("FAIL clean_press_pulse edge %0d: press=%b code=%0d want edge 6 0100 2",
                             e, key_press, key_code);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL clean_press_count: got %0d pulses want 1", pulses);
        end
        KEY_n[2] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec || key_valid !== 1'b0) begin
                errors++;
                $display("FAIL clean_release edge %0d: got %b want %b", e, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        logic [7:0] pattern = 8'b11001100;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            if (c > 0) begin
                checks++;
                if (dut_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL bounce cycle %0d: got %b want %b", c, dut_vec, exp_vec);
                end
                checks++;
                if (KEY_n_db[0] !== (c < 14)) begin
                    errors++;
                    $display("FAIL bounce_level cycle %0d: KEY_n_db[0]=%b", c, KEY_n_db[0]);
                end
                if (key_press[0]) begin
                    pulses++;
                    checks++;
                    if (c != 14) begin
                        errors++;
                        $display("FAIL bounce_pulse_time: got cycle %0d want 14", c);
                    end
                end
            end
            KEY_n[0] = (c < 8) ? pattern[c] : 1'b0;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL bounce_count: got %0d pulses want 1", pulses);
        end
        release_and_wait(8);
    endtask

    task automatic test_glitch();
        @(negedge clk);
        KEY_n[3] = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            if (e == 3) KEY_n[3] = 1'b1;
            checks++;
            if (KEY_n_db !== 4'b1111 || key_valid !== 1'b0 || dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL glitch edge %0d: got %b want %b", e, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        KEY_n[1] = 1'b0;
        KEY_n[2] = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL simult edge %0d: got %b want %b", e, dut_vec, exp_vec);
            end
            if (e == 6) begin
                checks++;
                if (key_press !== 4'b0110 || key_code !== 2'd1 || key_valid !== 1'b1 || multi_press !== 1'b1) begin
                    errors++;
                    $display("FAIL simult_pulse: press=%b code=%0d valid=%b multi=%b want 0110 1 1 1",
                             key_press, key_code, key_valid, multi_press);
                end
            end
            if (e == 7) begin
                checks++;
                if (key_valid !== 1'b0 || multi_press !== 1'b1) begin
                    errors++;
                    $display("FAIL simult_hold: valid=%b multi=%b want 0 1", key_valid, multi_press);
                end
            end
        end
        KEY_n[1] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            checks++;
            if (multi_press !== (e < 6) || dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL simult_release edge %0d: got %b want %b", e, dut_vec, exp_vec);
            end
        end
        release_and_wait(8);
    endtask

    task automatic test_switch();
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            if (c > 0) begin
                checks++;
                if (sw_db !== (c >= 8) || key_valid !== 1'b0 || key_press !== 4'b0000
                    || dut_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL switch cycle %0d: got %b want %b", c, dut_vec, exp_vec);
                end
            end
            sw_raw = (c != 1);
        end
        sw_raw = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            checks++;
            if (sw_db !== (e < 6) || dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL switch_off edge %0d: got %b want %b", e, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        int pulses = 0;
        @(negedge clk);
        KEY_n[0] = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_mid_count: got %b want %b", dut_vec, RESET_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec || KEY_n_db[0] !== (e < 6)) begin
                errors++;
                $display("FAIL reset_resume edge %0d: got %b want %b", e, dut_vec, exp_vec);
            end
            if (key_press[0]) begin
                pulses++;
                checks++;
                if (e != 6) begin
                    errors++;
                    $display("FAIL reset_resume_pulse: got edge %0d want 6", e);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL reset_resume_count: got %0d pulses want 1", pulses);
        end
        release_and_wait(8);
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL random cycle %0d: got %b want %b", c, dut_vec, exp_vec);
            end
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 5) == 0) KEY_n[k] = ~KEY_n[k];
            end
            if ($urandom_range(0, 7) == 0) sw_raw = ~sw_raw;
        end
        sw_raw = 1'b0;
        release_and_wait(8);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_switch();
        test_reset_mid_count();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Input-conditioning stage directly upstream of the safe-cracking FSM.
- Synchronises and debounces the four push-buttons KEY0..KEY3 (active-low) and the programming switch.
- Delivers clean active-low button levels and a clean switch level that drive the FSM inputs unchanged.
- Also delivers per-key press pulses, an encoded key code and a multi-press flag for display and diagnostic logic.

Parameters:
- CLOCK_HZ, 50_000_000: system clock frequency in Hz.
- DEBOUNCE_MS, 10: required stable time in ms. Derived localparam DB_CYCLES = CLOCK_HZ/1000*DEBOUNCE_MS, which must be >= 1.
- Simulation uses CLOCK_HZ=1000, DEBOUNCE_MS=4, giving DB_CYCLES=4.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- KEY_n  in  4  raw push-buttons, active-low, asynchronous, bouncing.
- sw_raw  in  1  raw programming switch, asynchronous, bouncing.
- KEY_n_db  out  4  debounced buttons, active-low; feed KEY0_n..KEY3_n of the FSM.
- sw_db  out  1  debounced switch level; feeds rst_sw of the FSM.
- key_press  out  4  one-cycle pulse per key on a debounced press.
- key_valid  out  1  one-cycle pulse when any bit of key_press is high.
- key_code  out  2  index of the lowest-numbered key in key_press; valid only while key_valid=1, otherwise 0.
- multi_press  out  1  level, high while two or more keys are debounced-pressed.

Behaviour:
- Channels: 5 identical channels (4 keys + switch). Keys are inverted to active-high internally. Each channel has:
  - a 2-FF synchroniser producing sample s;
  - a stable register st;
  - a counter cnt of width $clog2(DB_CYCLES+1).
- Per-channel rules, every clock:
  - s == st: cnt <= 0.
  - s != st and cnt < DB_CYCLES-1: cnt <= cnt+1.
  - s != st and cnt == DB_CYCLES-1: st <= s, cnt <= 0.
  - Net effect: st follows s only after DB_CYCLES consecutive samples differing from st. Any sample equal to st restarts the count.
- Latency: a clean raw transition reaches st (and KEY_n_db / sw_db) on the (DB_CYCLES+2)th rising edge after it. No change is ever shorter.
- Output mapping:
  - KEY_n_db[i] = ~st_key[i]; sw_db = st_sw.
  - Both are direct register outputs with no combinational path from the raw inputs.
- key_press[i]:
  - Registered; high exactly in the first cycle that st_key[i] is 1, computed from the 0->1 update of st_key[i].
  - Release generates no pulse. Holding a key generates no further pulses (no auto-repeat).
- key_valid / key_code:
  - Registered alongside key_press; key_valid = |key_press.
  - Simultaneous presses in one cycle: key_press shows all of them; key_code takes the lowest index.
- multi_press: registered from the popcount of st_key being >= 2; updates in the same cycle as st changes.
- Switch channel: produces no pulse outputs.
- Reset (rst_n=0, asynchronous, any time including mid-count):
  - Sync FFs and st take the released/off value: keys 0 internally, so KEY_n_db=4'b1111; sw_db=0.
  - cnt=0, key_press=0, key_valid=0, key_code=0, multi_press=0.
- After reset release: a key already held low needs the full DB_CYCLES+2 edges and then produces a key_press pulse. The switch already high likewise yields sw_db=1 after DB_CYCLES+2 edges.
- Counter wrap: cnt never exceeds DB_CYCLES-1, so no wrap is possible.

Test Plan:
(DB_CYCLES=4 in all scenarios)
- Clean press: KEY_n[2] 1->0 and held -> KEY_n_db[2]=0 on edge 6 after the change; key_press=4'b0100, key_valid=1, key_code=2 for exactly one cycle; nothing further while held.
- Bounce: KEY_n[0] toggles 0,1,0,1 every 2 cycles, then stays 0 -> exactly one key_press[0] pulse, 6 edges after the final transition; KEY_n_db[0] never glitches high-low-high before that.
- Short glitch: KEY_n[3] low for 3 cycles, then high -> KEY_n_db stays 4'b1111; key_valid never asserts.
- Simultaneous: KEY_n[1] and KEY_n[2] low on the same cycle -> key_press=4'b0110, key_code=1, key_valid=1 for one cycle; multi_press=1 until either key is debounced-released.
- Switch: sw_raw 0->1, bounce 1 cycle low, then stable high -> sw_db=1 six edges after the last transition; no pulse outputs.
- Reset mid-count: KEY_n[0] low for 3 cycles, pulse rst_n low for 1 cycle -> all outputs return to reset values immediately; a press then completes 6 edges after rst_n rises, with a single key_press[0] pulse.
